// File: rtl/motor_ramp_sched.sv
// motor_ramp_sched: slew-rate limited command scheduler feeding motor_cntrl.
// Accepts signed left/right duty targets over valid/ready, steps the
// registered drive values toward them once per update tick, parks a channel
// at zero on a direction reversal, and forces both outputs to zero on estop.
// Optional feature macro: MOTOR_BRAKE_DWELL_EN (adds the BRAKE dwell state).

module motor_ramp_sched #(
    parameter int STEP      = 64,
    parameter int TICK_DIV  = 1024,
    parameter int BRAKE_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [10:0] cmd_lft,
    input  logic [10:0] cmd_rht,
    input  logic        estop,
    output logic [10:0] lft,
    output logic [10:0] rht,
    output logic        busy,
    output logic        at_target
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RAMP  = 2'd1;
    localparam logic [1:0] ESTOP = 2'd3;
`ifdef MOTOR_BRAKE_DWELL_EN
    localparam logic [1:0] BRAKE = 2'd2;
    localparam int DW = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(BRAKE_CYC - 1);
`endif

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic signed [11:0] STEP12 = 12'(STEP);

    logic [1:0]         state, nxt_state;
    logic signed [10:0] lft_q, rht_q, nxt_lft, nxt_rht;
    logic signed [10:0] tgt_lft, tgt_rht, nxt_tgt_lft, nxt_tgt_rht;
    logic [TW-1:0]      tick_cnt, nxt_tick;
    logic               nxt_busy, nxt_at_target;
`ifdef MOTOR_BRAKE_DWELL_EN
    logic [DW-1:0]      dwell_cnt, nxt_dwell;
    logic               brake_hit;
`endif

    logic               tick, accept, done;
    logic signed [10:0] acc_lft, acc_rht, tgt_lft_n, tgt_rht_n;
    logic               rev_lft, rev_rht;
    logic signed [10:0] goal_lft, goal_rht, step_lft, step_rht;

    // -1024 has no 10-bit magnitude, so it is pulled in to -1023.
    function automatic logic signed [10:0] clamp11(input logic signed [10:0] v);
        return (v == 11'sh400) ? 11'sh401 : v;
    endfunction

    // One bounded step from cur toward goal, done at 12 bits so nothing wraps.
    function automatic logic signed [10:0] step_toward(input logic signed [10:0] cur,
                                                       input logic signed [10:0] goal);
        logic signed [11:0] c12, g12, d12, r12;
        c12 = {cur[10], cur};
        g12 = {goal[10], goal};
        d12 = g12 - c12;
        if ((d12 <= STEP12) && (d12 >= -STEP12))
            r12 = g12;
        else if (d12 > 12'sd0)
            r12 = c12 + STEP12;
        else
            r12 = c12 - STEP12;
        return r12[10:0];
    endfunction

    assign cmd_rdy   = (state != ESTOP);
    assign accept    = cmd_vld && cmd_rdy && !estop;
    assign tick      = (tick_cnt == TICK_LAST);
    assign acc_lft   = clamp11($signed(cmd_lft));
    assign acc_rht   = clamp11($signed(cmd_rht));
    assign tgt_lft_n = accept ? acc_lft : tgt_lft;
    assign tgt_rht_n = accept ? acc_rht : tgt_rht;

    // A channel whose drive and target are nonzero with opposite signs is
    // steered to zero first, so the motor never jumps straight across.
    assign rev_lft  = (lft_q != 11'sd0) && (tgt_lft != 11'sd0) && (lft_q[10] != tgt_lft[10]);
    assign rev_rht  = (rht_q != 11'sd0) && (tgt_rht != 11'sd0) && (rht_q[10] != tgt_rht[10]);
    assign goal_lft = rev_lft ? 11'sd0 : tgt_lft;
    assign goal_rht = rev_rht ? 11'sd0 : tgt_rht;
    assign step_lft = step_toward(lft_q, goal_lft);
    assign step_rht = step_toward(rht_q, goal_rht);
    assign done     = (step_lft == tgt_lft_n) && (step_rht == tgt_rht_n);
`ifdef MOTOR_BRAKE_DWELL_EN
    assign brake_hit = (rev_lft && (step_lft == 11'sd0)) || (rev_rht && (step_rht == 11'sd0));
`endif

    // Next-state logic: targets, stepping, dwell, and estop override last.
    always_comb begin
        nxt_state   = state;
        nxt_lft     = lft_q;
        nxt_rht     = rht_q;
        nxt_tgt_lft = tgt_lft_n;
        nxt_tgt_rht = tgt_rht_n;
        nxt_tick    = tick ? '0 : tick_cnt + 1'b1;
`ifdef MOTOR_BRAKE_DWELL_EN
        nxt_dwell   = dwell_cnt;
`endif
        case (state)
            IDLE: begin
                if (accept && ((acc_lft != lft_q) || (acc_rht != rht_q)))
                    nxt_state = RAMP;
            end
            RAMP: begin
                if (tick) begin
                    nxt_lft = step_lft;
                    nxt_rht = step_rht;
`ifdef MOTOR_BRAKE_DWELL_EN
                    if (brake_hit) begin
                        nxt_state = BRAKE;
                        nxt_dwell = '0;
                    end else if (done) begin
                        nxt_state = IDLE;
                    end
`else
                    if (done)
                        nxt_state = IDLE;
`endif
                end
            end
`ifdef MOTOR_BRAKE_DWELL_EN
            BRAKE: begin
                if (dwell_cnt == DWELL_LAST) begin
                    nxt_state = RAMP;
                    nxt_dwell = '0;
                end else begin
                    nxt_dwell = dwell_cnt + 1'b1;
                end
            end
`endif
            ESTOP: begin
                nxt_tick = '0;
                if (!estop)
                    nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase

        if (estop) begin
            nxt_state   = ESTOP;
            nxt_lft     = 11'sd0;
            nxt_rht     = 11'sd0;
            nxt_tgt_lft = 11'sd0;
            nxt_tgt_rht = 11'sd0;
            nxt_tick    = '0;
`ifdef MOTOR_BRAKE_DWELL_EN
            nxt_dwell   = '0;
`endif
        end

`ifdef MOTOR_BRAKE_DWELL_EN
        nxt_busy = (nxt_state == RAMP) || (nxt_state == BRAKE);
`else
        nxt_busy = (nxt_state == RAMP);
`endif
        nxt_at_target = (nxt_state == IDLE) && (nxt_lft == nxt_tgt_lft) && (nxt_rht == nxt_tgt_rht);
    end

    // State, drive, target and counter registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lft_q     <= 11'sd0;
            rht_q     <= 11'sd0;
            tgt_lft   <= 11'sd0;
            tgt_rht   <= 11'sd0;
            tick_cnt  <= '0;
            busy      <= 1'b0;
            at_target <= 1'b1;
`ifdef MOTOR_BRAKE_DWELL_EN
            dwell_cnt <= '0;
`endif
        end else begin
            state     <= nxt_state;
            lft_q     <= nxt_lft;
            rht_q     <= nxt_rht;
            tgt_lft   <= nxt_tgt_lft;
            tgt_rht   <= nxt_tgt_rht;
            tick_cnt  <= nxt_tick;
            busy      <= nxt_busy;
            at_target <= nxt_at_target;
`ifdef MOTOR_BRAKE_DWELL_EN
            dwell_cnt <= nxt_dwell;
`endif
        end
    end

    assign lft = lft_q;
    assign rht = rht_q;

endmodule

// File: tb/tb_motor_ramp_sched.sv
// Directed testbench for motor_ramp_sched (TICK_DIV=4, STEP=64, BRAKE_CYC=8).
// Expected reversal zero-hold length depends on MOTOR_BRAKE_DWELL_EN.

module tb_motor_ramp_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [10:0] cmd_lft = '0;
    logic [10:0] cmd_rht = '0;
    logic        estop = 1'b0;
    logic [10:0] lft, rht;
    logic        busy, at_target;

    int checks = 0;
    int failures = 0;
    int seq_l[$];
    int seq_r[$];
    int zero_max;
    bit timed_out;

    motor_ramp_sched #(.STEP(64), .TICK_DIV(4), .BRAKE_CYC(8)) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_lft(cmd_lft), .cmd_rht(cmd_rht), .estop(estop),
        .lft(lft), .rht(rht), .busy(busy), .at_target(at_target)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        rst = 1'b1;
        cmd_vld = 1'b0;
        estop = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input int l, input int r);
        cmd_lft = 11'(l);
        cmd_rht = 11'(r);
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    // Record every change of lft/rht until back at target, or the bound expires.
    task automatic capture(input int bound);
        logic [10:0] pl, pr;
        int run, c;
        seq_l.delete();
        seq_r.delete();
        zero_max = 0;
        run = 0;
        c = 0;
        timed_out = 1'b1;
        pl = lft;
        pr = rht;
        while (c < bound) begin
            @(negedge clk);
            c++;
            if (lft != pl) begin seq_l.push_back(int'($signed(lft))); pl = lft; end
            if (rht != pr) begin seq_r.push_back(int'($signed(rht))); pr = rht; end
            if (lft == 11'd0) begin run++; if (run > zero_max) zero_max = run; end
            else run = 0;
            if (at_target && !busy) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic wait_lft(input int val, input int bound);
        int c;
        c = 0;
        timed_out = 1'b1;
        while (c < bound) begin
            @(negedge clk);
            c++;
            if (int'($signed(lft)) == val) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (lft !== 11'd0) begin failures++; $display("[TB] FAIL reset_lft got=%0d exp=0", $signed(lft)); end
        checks++; if (rht !== 11'd0) begin failures++; $display("[TB] FAIL reset_rht got=%0d exp=0", $signed(rht)); end
        checks++; if (at_target !== 1'b1) begin failures++; $display("[TB] FAIL reset_at_target got=%b exp=1", at_target); end
        checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_rdy got=%b exp=1", cmd_rdy); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        send(0, 0);
        checks++; if (busy !== 1'b0 || at_target !== 1'b1) begin failures++; $display("[TB] FAIL idle_same_cmd busy=%b at_target=%b exp busy=0 at_target=1", busy, at_target); end
    endtask

    task automatic test_ramp_up();
        int exp_l[5] = '{64, 128, 192, 256, 300};
        int exp_r[2] = '{64, 100};
        int got;
        do_reset();
        send(300, 100);
        checks++; if (busy !== 1'b1 || at_target !== 1'b0) begin failures++; $display("[TB] FAIL ramp_start busy=%b at_target=%b exp busy=1 at_target=0", busy, at_target); end
        capture(200);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL ramp_timeout got=timeout exp=idle"); end
        checks++; if (seq_l.size() !== 5) begin failures++; $display("[TB] FAIL ramp_lft_count got=%0d exp=5", seq_l.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < seq_l.size()) ? seq_l[i] : 99999;
            checks++; if (got !== exp_l[i]) begin failures++; $display("[TB] FAIL ramp_lft[%0d] got=%0d exp=%0d", i, got, exp_l[i]); end
        end
        checks++; if (seq_r.size() !== 2) begin failures++; $display("[TB] FAIL ramp_rht_count got=%0d exp=2", seq_r.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < seq_r.size()) ? seq_r[i] : 99999;
            checks++; if (got !== exp_r[i]) begin failures++; $display("[TB] FAIL ramp_rht[%0d] got=%0d exp=%0d", i, got, exp_r[i]); end
        end
        checks++; if (at_target !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL ramp_done at_target=%b busy=%b exp 1/0", at_target, busy); end
    endtask

    task automatic test_reversal();
        int exp_l[8] = '{136, 72, 8, 0, -64, -128, -192, -200};
        int got, exp_zero;
`ifdef MOTOR_BRAKE_DWELL_EN
        exp_zero = 12;
`else
        exp_zero = 4;
`endif
        do_reset();
        send(200, 0);
        capture(200);
        checks++; if (int'($signed(lft)) !== 200 || timed_out) begin failures++; $display("[TB] FAIL rev_setup got=%0d exp=200", $signed(lft)); end
        send(-200, 0);
        capture(300);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL rev_timeout got=timeout exp=idle"); end
        checks++; if (seq_l.size() !== 8) begin failures++; $display("[TB] FAIL rev_lft_count got=%0d exp=8", seq_l.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < seq_l.size()) ? seq_l[i] : 99999;
            checks++; if (got !== exp_l[i]) begin failures++; $display("[TB] FAIL rev_lft[%0d] got=%0d exp=%0d", i, got, exp_l[i]); end
        end
        checks++; if (zero_max !== exp_zero) begin failures++; $display("[TB] FAIL rev_zero_hold got=%0d exp=%0d", zero_max, exp_zero); end
        checks++; if (seq_r.size() !== 0) begin failures++; $display("[TB] FAIL rev_rht_moved got=%0d exp=0", seq_r.size()); end
    endtask

    task automatic test_clamp();
        bit saw_min;
        send(-1024, 1023);
        capture(300);
        saw_min = 1'b0;
        foreach (seq_l[i]) if (seq_l[i] == -1024) saw_min = 1'b1;
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL clamp_timeout got=timeout exp=idle"); end
        checks++; if (int'($signed(lft)) !== -1023) begin failures++; $display("[TB] FAIL clamp_lft_final got=%0d exp=-1023", $signed(lft)); end
        checks++; if (int'($signed(rht)) !== 1023) begin failures++; $display("[TB] FAIL clamp_rht_final got=%0d exp=1023", $signed(rht)); end
        checks++; if (saw_min !== 1'b0) begin failures++; $display("[TB] FAIL clamp_never_min got=seen exp=absent"); end
        checks++; if (seq_l.size() !== 13) begin failures++; $display("[TB] FAIL clamp_lft_count got=%0d exp=13", seq_l.size()); end
        checks++; if (seq_r.size() !== 16) begin failures++; $display("[TB] FAIL clamp_rht_count got=%0d exp=16", seq_r.size()); end
    endtask

    task automatic test_retarget();
        int got;
        do_reset();
        send(500, 0);
        wait_lft(192, 100);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL retarget_reach192 got=timeout exp=192"); end
        send(100, 0);
        capture(100);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL retarget_timeout got=timeout exp=idle"); end
        checks++; if (seq_l.size() !== 2) begin failures++; $display("[TB] FAIL retarget_count got=%0d exp=2", seq_l.size()); end
        got = (seq_l.size() > 0) ? seq_l[0] : 99999;
        checks++; if (got !== 128) begin failures++; $display("[TB] FAIL retarget_first got=%0d exp=128", got); end
        got = (seq_l.size() > 1) ? seq_l[1] : 99999;
        checks++; if (got !== 100) begin failures++; $display("[TB] FAIL retarget_second got=%0d exp=100", got); end
    endtask

    task automatic test_estop();
        do_reset();
        send(500, 300);
        wait_lft(256, 100);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL estop_reach256 got=timeout exp=256"); end
        estop = 1'b1;
        cmd_vld = 1'b1;
        cmd_lft = 11'd400;
        cmd_rht = 11'd400;
        @(negedge clk);
        checks++; if (lft !== 11'd0 || rht !== 11'd0) begin failures++; $display("[TB] FAIL estop_zero got=%0d,%0d exp=0,0", $signed(lft), $signed(rht)); end
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("[TB] FAIL estop_rdy got=%b exp=0", cmd_rdy); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL estop_busy got=%b exp=0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (lft !== 11'd0 || cmd_rdy !== 1'b0) begin failures++; $display("[TB] FAIL estop_hold lft=%0d rdy=%b exp 0/0", $signed(lft), cmd_rdy); end
        estop = 1'b0;
        cmd_vld = 1'b0;
        @(negedge clk);
        checks++; if (cmd_rdy !== 1'b1 || at_target !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL estop_release rdy=%b at_target=%b busy=%b exp 1/1/0", cmd_rdy, at_target, busy); end
        repeat (12) @(negedge clk);
        checks++; if (lft !== 11'd0 || rht !== 11'd0 || at_target !== 1'b1) begin failures++; $display("[TB] FAIL estop_targets_cleared got=%0d,%0d at_target=%b exp=0,0,1", $signed(lft), $signed(rht), at_target); end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(300, 200);
        wait_lft(128, 100);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL areset_reach128 got=timeout exp=128"); end
        #2 rst = 1'b1;
        #1;
        checks++; if (lft !== 11'd0 || rht !== 11'd0) begin failures++; $display("[TB] FAIL areset_outputs got=%0d,%0d exp=0,0", $signed(lft), $signed(rht)); end
        checks++; if (busy !== 1'b0 || at_target !== 1'b1 || cmd_rdy !== 1'b1) begin failures++; $display("[TB] FAIL areset_flags busy=%b at_target=%b rdy=%b exp 0/1/1", busy, at_target, cmd_rdy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] motor_ramp_sched directed tests start");
        test_reset();
        test_ramp_up();
        test_reversal();
        test_clamp();
        test_retarget();
        test_estop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
